// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and bus slice helpers for the FIR
// producer-side feeder (fir_tap_feeder and fir_coeff_regfile).
//
// Flattened bus layout used by both oDelay and oCoeff: element k occupies
// [N*W-1-k*W -: W], so element 0 sits in the most significant slot.
package fir_pkg;

  localparam int TAPS   = 10;  // number of filter taps
  localparam int DATA_W = 3;   // sample width, two's complement
  localparam int COEF_W = 16;  // coefficient width
  localparam int OUT_W  = 16;  // MAC result width
  localparam int ADDR_W = 4;   // coefficient address width

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_ADD,
    ST_ACC,
    ST_OUT
  } state_e;

  // MSB index of tap k inside the flattened delay-line bus.
  function automatic int tap_hi(input int k);
    return TAPS * DATA_W - 1 - k * DATA_W;
  endfunction

  // MSB index of coefficient k inside the flattened coefficient bus.
  function automatic int coef_hi(input int k);
    return TAPS * COEF_W - 1 - k * COEF_W;
  endfunction

endpackage

// File: rtl/fir_coeff_regfile.sv
// TAPS x COEF_W coefficient register file for the FIR feeder.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset, clears every coefficient
//   wr_en_i    write strobe (caller already gates it to legal states)
//   wr_addr_i  coefficient index; indices >= TAPS are dropped
//   wr_data_i  coefficient value
//   coeff_o    flattened coefficients, coeff k at [TAPS*COEF_W-1-k*COEF_W -: COEF_W]
module fir_coeff_regfile
  import fir_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   wr_en_i,
  input  logic [ADDR_W-1:0]      wr_addr_i,
  input  logic [COEF_W-1:0]      wr_data_i,
  output logic [TAPS*COEF_W-1:0] coeff_o
);

  logic [COEF_W-1:0] coeff_q [TAPS];

  // Each register compares against its own index, so an out-of-range
  // address simply matches nothing and the write is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < TAPS; k++) coeff_q[k] <= '0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        if (wr_en_i && (wr_addr_i == ADDR_W'(k))) coeff_q[k] <= wr_data_i;
      end
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_pack
    assign coeff_o[coef_hi(k) -: COEF_W] = coeff_q[k];
  end

endmodule

// File: rtl/fir_tap_feeder.sv
// Producer side of the FIR MAC datapath: accepts samples, keeps the delay
// line and coefficients, sequences the MAC enables and hands the MAC result
// downstream.
//
// Ports:
//   iClk, iRsn             clock, asynchronous active-low reset
//   iCoeffWrEn/Addr/Data   coefficient write port (honoured in IDLE only)
//   iInValid/oInReady/iInData     sample input handshake
//   oEnMul/oEnAdd/oEnAcc   registered MAC enables
//   oDelay, oCoeff         flattened delay line (tap0 newest) and coefficients
//   iMacResult             result from the combinational MAC unit
//   oOutValid/iOutReady/oOutData  result output handshake
//   iClear                 only with FIR_FEEDER_CLEAR_EN: zero the delay line
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. Once valid is raised it stays up, with its data stable, until that
// transfer; ready never depends combinationally on the same-side valid.
//
// Build option FIR_FEEDER_CLEAR_EN adds iClear. In IDLE it zeroes the delay
// line on the next edge and masks oInReady, so a clear beats a same-cycle
// sample. Without it the delay line is cleared only by reset.
//
// The FSM state register state_q is the debug hook for checkers.
module fir_tap_feeder
  import fir_pkg::*;
(
  input  logic                   iClk,
  input  logic                   iRsn,
  input  logic                   iCoeffWrEn,
  input  logic [ADDR_W-1:0]      iCoeffAddr,
  input  logic [COEF_W-1:0]      iCoeffData,
  input  logic                   iInValid,
  output logic                   oInReady,
  input  logic [DATA_W-1:0]      iInData,
  output logic                   oEnMul,
  output logic                   oEnAdd,
  output logic                   oEnAcc,
  output logic [TAPS*DATA_W-1:0] oDelay,
  output logic [TAPS*COEF_W-1:0] oCoeff,
  input  logic [OUT_W-1:0]       iMacResult,
  output logic                   oOutValid,
  input  logic                   iOutReady,
`ifdef FIR_FEEDER_CLEAR_EN
  input  logic                   iClear,
`endif
  output logic [OUT_W-1:0]       oOutData
);

  state_e            state_q;
  logic              in_ready_q;
  logic              en_mul_q;
  logic              en_add_q;
  logic              en_acc_q;
  logic              out_valid_q;
  logic [OUT_W-1:0]  out_data_q;
  logic [DATA_W-1:0] tap_q [TAPS];
  logic [DATA_W-1:0] tap_d [TAPS];

  logic clear_req;
  logic in_idle;
  logic accept;
  logic clear_fire;
  logic coeff_we;

`ifdef FIR_FEEDER_CLEAR_EN
  assign clear_req = iClear;
`else
  assign clear_req = 1'b0;
`endif

  assign in_idle    = (state_q == ST_IDLE);
  assign oInReady   = in_ready_q & ~clear_req;
  assign accept     = in_idle & iInValid & oInReady;
  assign clear_fire = in_idle & clear_req;
  // Writes are blocked outside IDLE so oCoeff cannot move under a running
  // MAC sequence; a write in the accept cycle lands before MUL starts.
  assign coeff_we   = in_idle & iCoeffWrEn;

  fir_coeff_regfile u_coeff (
    .clk_i     (iClk),
    .rst_ni    (iRsn),
    .wr_en_i   (coeff_we),
    .wr_addr_i (iCoeffAddr),
    .wr_data_i (iCoeffData),
    .coeff_o   (oCoeff)
  );

  // Delay line: shift on accept (tap9 falls off), zero on clear.
  always_comb begin
    for (int k = 0; k < TAPS; k++) tap_d[k] = tap_q[k];
    if (clear_fire) begin
      for (int k = 0; k < TAPS; k++) tap_d[k] = '0;
    end else if (accept) begin
      for (int k = TAPS - 1; k > 0; k--) tap_d[k] = tap_q[k-1];
      tap_d[0] = iInData;
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      for (int k = 0; k < TAPS; k++) tap_q[k] <= '0;
    end else begin
      for (int k = 0; k < TAPS; k++) tap_q[k] <= tap_d[k];
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_delay
    assign oDelay[tap_hi(k) -: DATA_W] = tap_q[k];
  end

  // Sequencer. Every output register is loaded with the value that belongs
  // to the state being entered, so outputs line up with state_q and carry
  // no combinational path from the handshake inputs. in_ready_q resets to 0
  // and rises on the first edge after reset release.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      en_mul_q    <= 1'b0;
      en_add_q    <= 1'b0;
      en_acc_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q    <= ST_MUL;
            in_ready_q <= 1'b0;
            en_mul_q   <= 1'b1;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_MUL: begin
          state_q  <= ST_ADD;
          en_add_q <= 1'b1;
        end
        ST_ADD: begin
          state_q  <= ST_ACC;
          en_acc_q <= 1'b1;
        end
        ST_ACC: begin
          state_q     <= ST_OUT;
          en_mul_q    <= 1'b0;
          en_add_q    <= 1'b0;
          en_acc_q    <= 1'b0;
          out_valid_q <= 1'b1;
          out_data_q  <= iMacResult;
        end
        ST_OUT: begin
          if (iOutReady) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b0;
          en_mul_q    <= 1'b0;
          en_add_q    <= 1'b0;
          en_acc_q    <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign oEnMul    = en_mul_q;
  assign oEnAdd    = en_add_q;
  assign oEnAcc    = en_acc_q;
  assign oOutValid = out_valid_q;
  assign oOutData  = out_data_q;

endmodule

// File: tb/tb_fir_tap_feeder.sv
// Testbench for fir_tap_feeder. A behavioural MAC unit closes the loop on
// iMacResult; expected filter outputs are hand-computed constants pushed
// into exp_q when a sample is accepted and popped by the output monitor.
module tb_fir_tap_feeder;
  import fir_pkg::*;

  logic                   iClk;
  logic                   iRsn;
  logic                   iCoeffWrEn;
  logic [ADDR_W-1:0]      iCoeffAddr;
  logic [COEF_W-1:0]      iCoeffData;
  logic                   iInValid;
  logic                   oInReady;
  logic [DATA_W-1:0]      iInData;
  logic                   oEnMul;
  logic                   oEnAdd;
  logic                   oEnAcc;
  logic [TAPS*DATA_W-1:0] oDelay;
  logic [TAPS*COEF_W-1:0] oCoeff;
  logic [OUT_W-1:0]       iMacResult;
  logic                   oOutValid;
  logic                   iOutReady;
  logic [OUT_W-1:0]       oOutData;
`ifdef FIR_FEEDER_CLEAR_EN
  logic                   iClear;
`endif

  fir_tap_feeder dut (
    .iClk       (iClk),
    .iRsn       (iRsn),
    .iCoeffWrEn (iCoeffWrEn),
    .iCoeffAddr (iCoeffAddr),
    .iCoeffData (iCoeffData),
    .iInValid   (iInValid),
    .oInReady   (oInReady),
    .iInData    (iInData),
    .oEnMul     (oEnMul),
    .oEnAdd     (oEnAdd),
    .oEnAcc     (oEnAcc),
    .oDelay     (oDelay),
    .oCoeff     (oCoeff),
    .iMacResult (iMacResult),
    .oOutValid  (oOutValid),
    .iOutReady  (iOutReady),
`ifdef FIR_FEEDER_CLEAR_EN
    .iClear     (iClear),
`endif
    .oOutData   (oOutData)
  );

  // ---------------- clock / reset ----------------
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  // ---------------- MAC unit (combinational) ----------------
  always_comb begin
    iMacResult = '0;
    for (int k = 0; k < TAPS; k++) begin
      automatic logic [DATA_W-1:0] t  = oDelay[TAPS*DATA_W-1-k*DATA_W -: DATA_W];
      automatic logic [15:0]       sx = {{(16-DATA_W){t[DATA_W-1]}}, t};
      iMacResult = iMacResult + sx * oCoeff[TAPS*COEF_W-1-k*COEF_W -: COEF_W];
    end
  end

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  int               acc_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic             seen_valid = 1'b0;
  logic [COEF_W-1:0] coef_m [TAPS];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [TAPS*COEF_W-1:0] pack_coef();
    logic [TAPS*COEF_W-1:0] r;
    r = '0;
    for (int k = 0; k < TAPS; k++) r[TAPS*COEF_W-1-k*COEF_W -: COEF_W] = coef_m[k];
    return r;
  endfunction

  // Output monitor: latency on the rising edge of oOutValid, data on transfer.
  always @(negedge iClk) begin
    if (iRsn && oOutValid && !seen_valid) begin
      seen_valid = 1'b1;
      if (acc_q.size() == 0) chk("unexpected_valid", 1, 0);
      else chk("latency", 160'(cyc - acc_q.pop_front()), 160'd4);
    end
    if (iRsn && oOutValid && iOutReady) begin
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else chk("out_data", oOutData, exp_q.pop_front());
      seen_valid = 1'b0;
    end
    if (!iRsn) seen_valid = 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge iClk);
    while (!oInReady && n < 100) begin
      @(negedge iClk);
      n++;
    end
    if (!oInReady) chk("wait_idle_timeout", 0, 1);
  endtask

  task automatic wr_coef(input logic [ADDR_W-1:0] a, input logic [COEF_W-1:0] d);
    wait_idle();
    @(posedge iClk); #1;
    iCoeffWrEn = 1'b1; iCoeffAddr = a; iCoeffData = d;
    @(posedge iClk); #1;
    iCoeffWrEn = 1'b0;
  endtask

  // Presents one sample (optionally with a coefficient write in the same
  // cycles) and returns #1 after the accept edge, i.e. in the MUL state.
  task automatic send(input logic [DATA_W-1:0] d, input logic push, input logic [OUT_W-1:0] exp,
                      input logic we, input logic [ADDR_W-1:0] wa, input logic [COEF_W-1:0] wd);
    int n = 0;
    @(posedge iClk); #1;
    iInValid = 1'b1; iInData = d;
    iCoeffWrEn = we; iCoeffAddr = wa; iCoeffData = wd;
    @(negedge iClk);
    while (!oInReady && n < 100) begin
      @(negedge iClk);
      n++;
    end
    if (!oInReady) begin
      chk("accept_timeout", 0, 1);
      iInValid = 1'b0; iCoeffWrEn = 1'b0;
      return;
    end
    if (push) begin
      exp_q.push_back(exp);
      acc_q.push_back(cyc);
    end
    @(posedge iClk); #1;
    iInValid = 1'b0; iCoeffWrEn = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [TAPS*DATA_W-1:0] hold_delay;
  logic [TAPS*COEF_W-1:0] hold_coef;
  logic [OUT_W-1:0]       hold_data;

  initial begin
    iRsn = 1'b0; iCoeffWrEn = 1'b0; iCoeffAddr = '0; iCoeffData = '0;
    iInValid = 1'b0; iInData = '0; iOutReady = 1'b1;
`ifdef FIR_FEEDER_CLEAR_EN
    iClear = 1'b0;
`endif
    for (int k = 0; k < TAPS; k++) coef_m[k] = '0;

    // Reset state
    repeat (2) @(negedge iClk);
    chk("rst_delay", oDelay, 0);
    chk("rst_coeff", oCoeff, 0);
    chk("rst_out_data", oOutData, 0);
    chk("rst_enables", {oEnMul, oEnAdd, oEnAcc, oOutValid}, 0);
    chk("rst_in_ready", oInReady, 0);
    iRsn = 1'b1;
    #1 chk("ready_before_edge", oInReady, 0);
    @(posedge iClk); #1;
    chk("ready_after_release", oInReady, 1);

    // Impulse through coefficients 1..10
    for (int k = 0; k < TAPS; k++) begin
      wr_coef(ADDR_W'(k), COEF_W'(k + 1));
      coef_m[k] = COEF_W'(k + 1);
    end
    wait_idle();
    chk("coeff_1_to_10", oCoeff, pack_coef());
    send(3'b001, 1'b1, 16'd1, 1'b0, '0, '0);
    chk("seq_mul", {oEnMul, oEnAdd, oEnAcc, oInReady}, 4'b1000);
    @(posedge iClk); #1;
    chk("seq_add", {oEnMul, oEnAdd, oEnAcc, oInReady}, 4'b1100);
    @(posedge iClk); #1;
    chk("seq_acc", {oEnMul, oEnAdd, oEnAcc, oInReady, oOutValid}, 5'b11100);
    @(posedge iClk); #1;
    chk("seq_out", {oEnMul, oEnAdd, oEnAcc, oInReady, oOutValid}, 5'b00001);
    for (int i = 1; i <= 10; i++) send(3'b000, 1'b1, (i < 10) ? OUT_W'(i + 1) : 16'd0, 1'b0, '0, '0);

    // Negative sample: coeff0=5 only
    wr_coef(4'd0, 16'd5);
    coef_m[0] = 16'd5;
    for (int k = 1; k < TAPS; k++) begin
      wr_coef(ADDR_W'(k), 16'd0);
      coef_m[k] = 16'd0;
    end
    send(3'b111, 1'b1, 16'hFFFB, 1'b0, '0, '0);
    send(3'b011, 1'b1, 16'h000F, 1'b0, '0, '0);

    // Downstream back-pressure: taps become 2,3,-1 -> 2*5 = 10
    wait_idle();
    @(posedge iClk); #1;
    iOutReady = 1'b0;
    send(3'b010, 1'b1, 16'h000A, 1'b0, '0, '0);
    begin
      int n = 0;
      @(negedge iClk);
      while (!oOutValid && n < 20) begin
        @(negedge iClk);
        n++;
      end
    end
    hold_delay = oDelay; hold_coef = oCoeff; hold_data = oOutData;
    chk("hold_data_value", hold_data, 16'h000A);
    iInValid = 1'b1; iInData = 3'b001;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", oOutValid, 1);
      chk("hold_data", oOutData, hold_data);
      chk("hold_delay", oDelay, hold_delay);
      chk("hold_coeff", oCoeff, hold_coef);
      chk("hold_ready", oInReady, 0);
      @(negedge iClk);
    end
    @(posedge iClk); #1;
    iOutReady = 1'b1; iInValid = 1'b0;
    @(posedge iClk); #1;
    chk("hold_released", {oOutValid, oInReady}, 2'b01);
    chk("hold_sample_ignored", oDelay, hold_delay);

    // Coefficient write rules
    wr_coef(4'd12, 16'hBEEF);
    chk("coeff_addr_range", oCoeff, pack_coef());
    send(3'b000, 1'b1, 16'h0000, 1'b0, '0, '0);  // taps 0,2,3,-1
    @(posedge iClk); #1;                          // now ADD
    iCoeffWrEn = 1'b1; iCoeffAddr = 4'd2; iCoeffData = 16'd7;
    @(posedge iClk); #1;
    iCoeffWrEn = 1'b0;
    chk("coeff_write_busy", oCoeff, pack_coef());
    // taps 1,0,2,3,-1 with coeff0=5, coeff2=7 -> 5 + 14 = 19
    send(3'b001, 1'b1, 16'h0013, 1'b1, 4'd2, 16'd7);
    coef_m[2] = 16'd7;
    chk("coeff_write_with_accept", oCoeff, pack_coef());

    // Reset during ACC aborts the sequence
    send(3'b001, 1'b0, '0, 1'b0, '0, '0);
    @(posedge iClk); #1;
    @(posedge iClk); #1;
    chk("abort_in_acc", oEnAcc, 1);
    #2 iRsn = 1'b0;
    #1;
    chk("abort_enables", {oEnMul, oEnAdd, oEnAcc, oOutValid, oInReady}, 0);
    chk("abort_delay", oDelay, 0);
    chk("abort_coeff", oCoeff, 0);
    chk("abort_out_data", oOutData, 0);
    for (int k = 0; k < TAPS; k++) coef_m[k] = '0;
    @(negedge iClk);
    iRsn = 1'b1;
    @(posedge iClk); #1;
    chk("abort_ready_back", oInReady, 1);
    repeat (6) @(negedge iClk);
    chk("abort_no_valid", oOutValid, 0);
    for (int k = 0; k < TAPS; k++) begin
      wr_coef(ADDR_W'(k), COEF_W'(k + 1));
      coef_m[k] = COEF_W'(k + 1);
    end
    send(3'b010, 1'b1, 16'd2, 1'b0, '0, '0);

`ifdef FIR_FEEDER_CLEAR_EN
    // Fill taps with 2: after j more samples result is (j+1)(j+2)
    for (int j = 1; j <= 9; j++) send(3'b010, 1'b1, OUT_W'((j + 1) * (j + 2)), 1'b0, '0, '0);
    wait_idle();
    chk("clear_pre_taps", oDelay, {TAPS{3'b010}});
    @(posedge iClk); #1;
    iClear = 1'b1; iInValid = 1'b1; iInData = 3'b101;
    @(negedge iClk);
    chk("clear_ready_masked", oInReady, 0);
    @(posedge iClk); #1;
    iClear = 1'b0; iInValid = 1'b0;
    chk("clear_delay", oDelay, 0);
    chk("clear_no_accept", oEnMul, 0);
    chk("clear_coeff_kept", oCoeff, pack_coef());
`endif

    // Drain
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        @(negedge iClk);
        n++;
      end
    end
    chk("drain_exp_q", 160'(exp_q.size()), 0);
    chk("drain_acc_q", 160'(acc_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
